seg7_scan_driver: RTL

- Four-digit time-multiplexed seven-segment driver for the Basys3 display.
- Sits downstream of the cpu core. It takes a 16-bit value (e.g. reg5_val[15:0]) and scans it across all four digits, replacing the single static digit.
- Value updates are double-buffered and committed only at frame boundaries, so the display never tears mid-scan.
- Includes an anti-ghosting blank interval at the start of each digit slot.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_hex_decode.sv | 33 +++
 rtl/seg7_scan_driver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scan driver.
// Segment codes are active-low, packed g..a (bit 6 = g, bit 0 = a).
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Nibble lookup into the shared segment-code table
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned DW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] digit_q, digit_d;
    logic [15:0]   disp_val_q, disp_val_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_valid_q, pend_valid_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;

    logic          boundary_s;
    slot_e         slot_s;
    logic [3:0]    nibble_s;
    logic [6:0]    dec_seg_s;
    logic          lz_blank_s;

    assign boundary_s = (cnt_q == CNT_LAST) && (digit_q == DIG_LAST);
    assign slot_s     = (cnt_q < CNT_BLANK) ? SLOT_BLANK : SLOT_DRIVE;

    // Select the display nibble for the digit currently being scanned
    always_comb begin
        nibble_s = 4'h0;
        case (digit_q)
            2'd0:    nibble_s = disp_val_q[3:0];
            2'd1:    nibble_s = disp_val_q[7:4];
            2'd2:    nibble_s = disp_val_q[11:8];
            2'd3:    nibble_s = disp_val_q[15:12];
            default: nibble_s = 4'h0;
        endcase
    end

    seg7_hex_decode u_dec (
        .nibble_i (nibble_s),
        .seg_o    (dec_seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is suppressed when it and every more-significant nibble are zero
    always_comb begin
        lz_blank_s = 1'b0;
        case (digit_q)
            2'd1:    lz_blank_s = (disp_val_q[15:4] == 12'h000);
            2'd2:    lz_blank_s = (disp_val_q[15:8] == 8'h00);
            2'd3:    lz_blank_s = (disp_val_q[15:12] == 4'h0);
            default: lz_blank_s = 1'b0;
        endcase
    end
`else
    // Every digit is always decoded
    always_comb begin
        lz_blank_s = 1'b0;
    end
`endif

    // Slot counter, digit rotation and frame-synchronous buffer commit
    always_comb begin
        cnt_d        = cnt_q + CW'(1);
        digit_d      = digit_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        tick_d       = boundary_s;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = {CW{1'b0}};
            digit_d = digit_q + DW'(1);
        end else begin
            cnt_d   = cnt_q + CW'(1);
        end
        // A load on the boundary itself bypasses the pending buffer
        if (boundary_s) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
            end else if (pend_valid_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end else begin
                disp_val_d = disp_val_q;
                disp_dp_d  = disp_dp_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Next-cycle pin values for the current slot
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        dp_d  = 1'b1;
        if (slot_s == SLOT_DRIVE) begin
            an_d  = AN_OFF ^ (4'b0001 << digit_q);
            seg_d = lz_blank_s ? SEG_BLANK : dec_seg_s;
            dp_d  = ~disp_dp_q[digit_q];
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= {CW{1'b0}};
            digit_q      <= {DW{1'b0}};
            disp_val_q   <= 16'h0000;
            disp_dp_q    <= 4'h0;
            pend_val_q   <= 16'h0000;
            pend_dp_q    <= 4'h0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            dp_q         <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            tick_q       <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule
